seq_multiplier: RTL

- Iterative shift-and-add unsigned multiplier for the execute stage; implements MUL (low WIDTH bits of the product).
- Consumes the result of the team's ripple-carry `adder` each cycle: one `adder` instance forms acc + partial product.
- Start/busy/done handshake lets the pipeline control stall the execute stage until `done`.

---
 rtl/seq_multiplier.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add unsigned multiplier returning the low WIDTH bits of A*B.
// One add per cycle through a ripple-carry adder; start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; result/overflow hold the last product
// RUN   | one shift-and-add iteration per cycle, WIDTH iterations
// DONE  | one-cycle done pulse, result/overflow valid

module adder #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut,
   output logic             overflow
);
   logic [WIDTH:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign carryOut = c[WIDTH];
   assign overflow = c[WIDTH] ^ c[WIDTH-1];
endmodule

module seq_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);
   if (WIDTH < 2) begin : g_width_check
      $error("seq_multiplier: WIDTH must be >= 2");
   end

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, m, q;
   logic [CW-1:0]    count;
   logic             mlost, ovf;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             last_iter;

   adder #(.WIDTH(WIDTH)) u_adder (
      .a        (acc),
      .b        (m),
      .sum      (sum),
      .carryOut (carry),
      .overflow ()
   );

   assign last_iter = (count == LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)     state_nxt = RUN;
         RUN:     if (last_iter) state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // A set mlost means a bit of M has already been shifted out, so any later add overflows.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         m        <= '0;
         q        <= '0;
         count    <= '0;
         mlost    <= 1'b0;
         ovf      <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m     <= multiplicand;
                  q     <= multiplier;
                  acc   <= '0;
                  count <= '0;
                  mlost <= 1'b0;
                  ovf   <= 1'b0;
               end
            end
            RUN: begin
               if (q[0]) begin
                  acc <= sum;
                  if (carry || mlost) ovf <= 1'b1;
               end
               if (m[WIDTH-1]) mlost <= 1'b1;
               m     <= m << 1;
               q     <= q >> 1;
               count <= count + 1'b1;
               if (last_iter) begin
                  result   <= q[0] ? sum : acc;
                  overflow <= ovf | (q[0] & (carry | mlost));
               end
            end
            default: ;
         endcase
      end
   end
endmodule
